// File: rtl/regfile_wb_pkg.sv
// Shared definitions for the register-file write arbiter: parameter defaults,
// the FIFO entry layout and pointer/level width helpers.
package regfile_wb_pkg;

    localparam int N_DEF          = 32;
    localparam int ADDR_DEF       = 5;
    localparam int DEPTH_DEF      = 4;
    localparam int STARVE_MAX_DEF = 8;

    // Entry layout at the default widths; the top rebuilds it from its own parameters.
    typedef struct packed {
        logic [ADDR_DEF-1:0] rd;
        logic [N_DEF-1:0]    data;
    } wb_entry_t;

    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction

    function automatic int lvl_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO buffering load/multiply writebacks; power-of-two depth,
// pointers wrap naturally, async active-low reset flushes it.
module wb_fifo
    import regfile_wb_pkg::*;
#(
    parameter int W     = 37,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      push_i,
    input  logic                      pop_i,
    input  logic [W-1:0]              wdata_i,
    output logic [W-1:0]              rdata_o,
    output logic                      full_o,
    output logic                      empty_o,
    output logic [lvl_w(DEPTH)-1:0]   level_o
);

    localparam int PW = ptr_w(DEPTH);
    localparam int LW = lvl_w(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          do_push, do_pop;

    assign full_o  = (level_q == LW'(DEPTH));
    assign empty_o = (level_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rptr_q];
    assign level_o = level_q;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;
        if (do_push) wptr_d = wptr_q + 1'b1;
        if (do_pop)  rptr_d = rptr_q + 1'b1;
        if (do_push && !do_pop)      level_d = level_q + 1'b1;
        else if (do_pop && !do_push) level_d = level_q - 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
        end
    end

    // Storage needs no reset: the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= wdata_i;
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Merges ALU and load/mul writebacks onto the single register-file write port,
// with FIFO buffering and starvation-forced drains. WB_SCOREBOARD_EN adds pending_o.
module regfile_write_arbiter
    import regfile_wb_pkg::*;
#(
    parameter int N          = N_DEF,
    parameter int ADDR       = ADDR_DEF,
    parameter int DEPTH      = DEPTH_DEF,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     alu_valid_i,
    input  logic [ADDR-1:0]          alu_reg_i,
    input  logic [N-1:0]             alu_data_i,
    output logic                     alu_stall_o,
    input  logic                     ls_valid_i,
    output logic                     ls_ready_o,
    input  logic [ADDR-1:0]          ls_reg_i,
    input  logic [N-1:0]             ls_data_i,
    output logic                     Reg_Write_o,
    output logic [ADDR-1:0]          Write_Register_o,
    output logic [N-1:0]             Write_Data_o,
    output logic [lvl_w(DEPTH)-1:0]  fifo_level_o
`ifdef WB_SCOREBOARD_EN
    ,
    output logic [2**ADDR-1:0]       pending_o
`endif
);

    localparam int LW = lvl_w(DEPTH);
    // One spare count above STARVE_MAX: age can tick once more while the stall is pending.
    localparam int AW = $clog2(STARVE_MAX + 2);

    typedef struct packed {
        logic [ADDR-1:0] rd;
        logic [N-1:0]    data;
    } entry_t;

    entry_t          push_ent, head;
    logic            fifo_full, fifo_empty;
    logic            push, pop, alu_eff;
    logic [AW-1:0]   age_q, age_d;
    logic            stall_q, stall_d;
    logic            we_q, we_d;
    logic [ADDR-1:0] wreg_q, wreg_d;
    logic [N-1:0]    wdata_q, wdata_d;

    assign ls_ready_o = !fifo_full;
    assign push       = ls_valid_i && ls_ready_o && (ls_reg_i != '0);
    assign push_ent   = '{rd: ls_reg_i, data: ls_data_i};
    assign alu_eff    = alu_valid_i && (alu_reg_i != '0) && !stall_q;

    wb_fifo #(.W($bits(entry_t)), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (push_ent),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level_o)
    );

    // The FIFO wins when forced by a stall or when the ALU has nothing to write.
    always_comb begin
        pop     = 1'b0;
        we_d    = 1'b0;
        wreg_d  = wreg_q;
        wdata_d = wdata_q;
        if (!fifo_empty && (stall_q || !alu_eff)) begin
            pop     = 1'b1;
            we_d    = 1'b1;
            wreg_d  = head.rd;
            wdata_d = head.data;
        end else if (alu_eff) begin
            we_d    = 1'b1;
            wreg_d  = alu_reg_i;
            wdata_d = alu_data_i;
        end
    end

    always_comb begin
        age_d   = age_q;
        stall_d = (age_q == AW'(STARVE_MAX));
        if (fifo_empty || pop)           age_d = '0;
        else if (age_q <= AW'(STARVE_MAX)) age_d = age_q + 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            age_q   <= '0;
            stall_q <= 1'b0;
            we_q    <= 1'b0;
            wreg_q  <= '0;
            wdata_q <= '0;
        end else begin
            age_q   <= age_d;
            stall_q <= stall_d;
            we_q    <= we_d;
            wreg_q  <= wreg_d;
            wdata_q <= wdata_d;
        end
    end

    assign alu_stall_o      = stall_q;
    assign Reg_Write_o      = we_q;
    assign Write_Register_o = wreg_q;
    assign Write_Data_o     = wdata_q;

`ifdef WB_SCOREBOARD_EN
    for (genvar r = 0; r < 2**ADDR; r++) begin : g_sb
        if (r == 0) begin : g_r0
            assign pending_o[r] = 1'b0;
        end else begin : g_rn
            logic [LW-1:0] cnt_q, cnt_d;
            logic          inc, dec;

            assign inc = push && (ls_reg_i == ADDR'(r));
            assign dec = pop && (head.rd == ADDR'(r));

            always_comb begin
                cnt_d = cnt_q;
                if (inc && !dec)      cnt_d = cnt_q + 1'b1;
                else if (dec && !inc) cnt_d = cnt_q - 1'b1;
            end

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) cnt_q <= '0;
                else        cnt_q <= cnt_d;
            end

            assign pending_o[r] = (cnt_q != '0);
        end
    end
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: a queue-based model of the arbitration
// rules checked every cycle, plus hand-computed literal expectations.
module tb_regfile_write_arbiter;

    localparam int N     = 32;
    localparam int ADDR  = 5;
    localparam int DEPTH = 4;
    localparam int SM    = 8;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            alu_valid = 1'b0;
    logic [ADDR-1:0] alu_reg = '0;
    logic [N-1:0]    alu_data = '0;
    logic            ls_valid = 1'b0;
    logic [ADDR-1:0] ls_reg = '0;
    logic [N-1:0]    ls_data = '0;
    logic            alu_stall, ls_ready, reg_write;
    logic [ADDR-1:0] write_reg;
    logic [N-1:0]    write_data;
    logic [2:0]      fifo_level;
`ifdef WB_SCOREBOARD_EN
    logic [31:0]     pending;
`endif

    always #5 clk = ~clk;

    regfile_write_arbiter #(.N(N), .ADDR(ADDR), .DEPTH(DEPTH), .STARVE_MAX(SM)) dut (
        .clk              (clk),
        .reset            (reset),
        .alu_valid_i      (alu_valid),
        .alu_reg_i        (alu_reg),
        .alu_data_i       (alu_data),
        .alu_stall_o      (alu_stall),
        .ls_valid_i       (ls_valid),
        .ls_ready_o       (ls_ready),
        .ls_reg_i         (ls_reg),
        .ls_data_i        (ls_data),
        .Reg_Write_o      (reg_write),
        .Write_Register_o (write_reg),
        .Write_Data_o     (write_data),
        .fifo_level_o     (fifo_level)
`ifdef WB_SCOREBOARD_EN
        ,
        .pending_o        (pending)
`endif
    );

    typedef struct {
        logic [ADDR-1:0] r;
        logic [N-1:0]    d;
    } ent_t;

    ent_t            q[$];
    int              m_age;
    bit              m_stall, m_we;
    logic [ADDR-1:0] m_reg;
    logic [N-1:0]    m_data;
    int              n_chk = 0;
    int              n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_age = 0; m_stall = 0; m_we = 0; m_reg = '0; m_data = '0;
    endtask

    // One clock edge of the arbiter, taken directly from the priority rules.
    task automatic model_step();
        bit   was_empty, ready, alu_ok, popped, next_stall;
        ent_t e;
        was_empty  = (q.size() == 0);
        ready      = (q.size() != DEPTH);
        alu_ok     = alu_valid && (alu_reg != 0) && !m_stall;
        next_stall = (m_age == SM);
        popped     = 0;
        if (m_stall && !was_empty) begin
            e = q.pop_front(); popped = 1;
            m_we = 1; m_reg = e.r; m_data = e.d;
        end else if (alu_ok) begin
            m_we = 1; m_reg = alu_reg; m_data = alu_data;
        end else if (!was_empty) begin
            e = q.pop_front(); popped = 1;
            m_we = 1; m_reg = e.r; m_data = e.d;
        end else begin
            m_we = 0;
        end
        m_age   = (was_empty || popped) ? 0 : m_age + 1;
        m_stall = next_stall;
        if (ls_valid && ready && ls_reg != 0) q.push_back('{ls_reg, ls_data});
    endtask

    function automatic logic [31:0] exp_pending();
        logic [31:0] p = '0;
        foreach (q[i]) p[q[i].r] = 1'b1;
        return p;
    endfunction

    task automatic compare();
        chk("reg_write",  reg_write,  m_we);
        chk("write_reg",  write_reg,  m_reg);
        chk("write_data", write_data, m_data);
        chk("fifo_level", fifo_level, q.size());
        chk("ls_ready",   ls_ready,   q.size() != DEPTH);
        chk("alu_stall",  alu_stall,  m_stall);
`ifdef WB_SCOREBOARD_EN
        chk("pending",    pending,    exp_pending());
`endif
    endtask

    // Inputs are set at the falling edge; the rising edge samples them.
    task automatic cyc();
        model_step();
        @(posedge clk);
        @(negedge clk);
        compare();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_we"},    reg_write,  1'b0);
        chk({tag, "_reg"},   write_reg,  '0);
        chk({tag, "_data"},  write_data, '0);
        chk({tag, "_level"}, fifo_level, '0);
        chk({tag, "_stall"}, alu_stall,  1'b0);
        chk({tag, "_ready"}, ls_ready,   1'b1);
`ifdef WB_SCOREBOARD_EN
        chk({tag, "_pend"},  pending,    '0);
`endif
    endtask

    initial begin
        model_reset();
        #1 reset = 1'b0;
        #1 chk_reset_outputs("por");
        @(negedge clk);
        reset = 1'b1;

        // ALU only
        alu_valid = 1; alu_reg = 3; alu_data = 32'hDEADBEEF;
        cyc();
        chk("alu_we", reg_write, 1'b1);
        chk("alu_reg", write_reg, 5'd3);
        chk("alu_data", write_data, 32'hDEADBEEF);
        chk("alu_ready", ls_ready, 1'b1);
        alu_valid = 0;

        // LS only: accepted, then issued at the following edge
        ls_valid = 1; ls_reg = 7; ls_data = 32'h12;
        cyc();
        chk("ls_level1", fifo_level, 3'd1);
        chk("ls_we0", reg_write, 1'b0);
        ls_valid = 0;
        cyc();
        chk("ls_we1", reg_write, 1'b1);
        chk("ls_reg", write_reg, 5'd7);
        chk("ls_data", write_data, 32'h12);
        chk("ls_level0", fifo_level, 3'd0);

        // r0 from both sources is dropped
        alu_valid = 1; alu_reg = 0; alu_data = 32'h1111;
        ls_valid = 1; ls_reg = 0; ls_data = 32'h2222;
        chk("r0_ready", ls_ready, 1'b1);
        cyc();
        chk("r0_we", reg_write, 1'b0);
        chk("r0_level", fifo_level, 3'd0);
        ls_valid = 0; alu_valid = 0;
        cyc();

        // Fill FIFO behind a continuously valid ALU, then starve into a forced drain
        alu_valid = 1; alu_reg = 1;
        for (int i = 0; i < 4; i++) begin
            alu_data = 32'hA000_0000 + i;
            ls_valid = 1;
            ls_reg   = (i < 2) ? 5'd5 : 5'(i + 4);
            ls_data  = 32'h5A5A_0000 + i;
            cyc();
`ifdef WB_SCOREBOARD_EN
            chk("sb_pend5", pending[5], 1'b1);
`endif
        end
        chk("full_ready", ls_ready, 1'b0);
        chk("full_level", fifo_level, 3'd4);
        ls_reg = 9; ls_data = 32'h9999;
        alu_data = 32'hA000_0004;
        cyc();
        chk("full_nopush", fifo_level, 3'd4);
        ls_valid = 0;
        for (int i = 5; i < 9; i++) begin
            alu_data = 32'hA000_0000 + i;
            cyc();
            chk("pre_stall", alu_stall, 1'b0);
        end
        alu_data = 32'hA000_0009;
        cyc();
        chk("stall_hi", alu_stall, 1'b1);
        chk("stall_alu_data", write_data, 32'hA000_0009);
        alu_data = 32'hBAD0_0BAD;
        cyc();
        chk("stall_lo", alu_stall, 1'b0);
        chk("drain_we", reg_write, 1'b1);
        chk("drain_reg", write_reg, 5'd5);
        chk("drain_data", write_data, 32'h5A5A_0000);
        chk("drain_level", fifo_level, 3'd3);
`ifdef WB_SCOREBOARD_EN
        chk("sb_still5", pending[5], 1'b1);
`endif
        alu_valid = 0;
        cyc();
        chk("drain2_reg", write_reg, 5'd5);
        chk("drain2_data", write_data, 32'h5A5A_0001);
`ifdef WB_SCOREBOARD_EN
        chk("sb_clear5", pending[5], 1'b0);
`endif
        cyc();
        cyc();
        chk("drained", fifo_level, 3'd0);
        cyc();

        // Async reset with three entries in flight
        alu_valid = 1; alu_reg = 2; alu_data = 32'hC0C0;
        for (int i = 0; i < 3; i++) begin
            ls_valid = 1; ls_reg = 5'(10 + i); ls_data = 32'hE0 + i;
            cyc();
        end
        chk("rst_level3", fifo_level, 3'd3);
        ls_valid = 0; alu_valid = 0;
        #2 reset = 1'b0;
        model_reset();
        #1 chk_reset_outputs("arst");
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("no_stale", reg_write, 1'b0);
        end

        // Mixed directed traffic, model-checked every cycle
        for (int i = 0; i < 48; i++) begin
            alu_valid = (i % 4) != 3;
            alu_reg   = 5'(i % 6);
            alu_data  = 32'(i) * 32'h0101_0101;
            ls_valid  = (i % 3) != 0;
            ls_reg    = 5'((i * 7) % 32);
            ls_data   = ~32'(i);
            cyc();
        end
        alu_valid = 0; ls_valid = 0;
        for (int i = 0; i < 10; i++) cyc();
        chk("final_empty", fifo_level, 3'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
